// File: rtl/quant_wb_ctrl_if.sv
// rtl/quant_wb_ctrl_if.sv - Bus bundle between the quantizer, the write-back controller and the result SRAM
//
// Purpose: groups the tile-control, quantizer row-select and SRAM write
// request signals of quant_wb_ctrl so they travel as one port.
// Ports (signals):
//   start, base_addr, num_rows  tile request and its configuration
//   row_sel, quant_data         quantizer row select and same-cycle row data
//   wr_valid, wr_ready          SRAM write handshake
//   wr_addr, wr_data            SRAM write address and registered row data
//   busy, done, stall_cnt       status
// Modports: slave = controller side, master = environment side.
interface quant_wb_ctrl_if #(
    parameter int ARRAY_SIZE        = 32,
    parameter int OUTPUT_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH        = 10
);
    logic                                   start;
    logic [ADDR_WIDTH-1:0]                  base_addr;
    logic [$clog2(ARRAY_SIZE):0]            num_rows;
    logic [$clog2(ARRAY_SIZE)-1:0]          row_sel;
    logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] quant_data;
    logic                                   wr_valid;
    logic                                   wr_ready;
    logic [ADDR_WIDTH-1:0]                  wr_addr;
    logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] wr_data;
    logic                                   busy;
    logic                                   done;
    logic [15:0]                            stall_cnt;

    modport slave (
        input  start, base_addr, num_rows, quant_data, wr_ready,
        output row_sel, wr_valid, wr_addr, wr_data, busy, done, stall_cnt
    );

    modport master (
        output start, base_addr, num_rows, quant_data, wr_ready,
        input  row_sel, wr_valid, wr_addr, wr_data, busy, done, stall_cnt
    );
endinterface

// File: rtl/quant_wb_ctrl.sv
// rtl/quant_wb_ctrl.sv - Drains quantized systolic-array result rows into SRAM, one write per row
//
// Purpose: on start, walks rows 0..N-1 of the array, registers each
// quantized row and issues one SRAM write per row at base+row (address
// wraps modulo 2^ADDR_WIDTH), then pulses done for one cycle.
// Ports:
//   clk    single clock, rising-edge state updates
//   rst_n  asynchronous active-low reset
//   bus    quant_wb_ctrl_if.slave (start/base_addr/num_rows in,
//          row_sel/quant_data, wr_valid/wr_ready/wr_addr/wr_data,
//          busy/done/stall_cnt)
// Optional feature macro: WB_STALL_CNT_EN enables the saturating
// stall-cycle counter; without it stall_cnt is tied to zero.
module quant_wb_ctrl #(
    parameter int ARRAY_SIZE        = 32,
    parameter int OUTPUT_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH        = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    quant_wb_ctrl_if.slave  bus
);
    localparam int ROW_W  = $clog2(ARRAY_SIZE);
    localparam int CNT_W  = $clog2(ARRAY_SIZE) + 1;
    localparam int DATA_W = ARRAY_SIZE * OUTPUT_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e              state_q,   state_d;
    logic [ADDR_WIDTH-1:0] base_q,  base_d;
    logic [CNT_W-1:0]    rows_q,    rows_d;
    logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic [CNT_W-1:0]    eff_rows;
    logic                last_row;
    logic                start_acc;

    // Zero or oversized requests mean "the whole array".
    always_comb begin
        eff_rows = bus.num_rows;
        if (bus.num_rows == '0 || bus.num_rows > CNT_W'(ARRAY_SIZE)) begin
            eff_rows = CNT_W'(ARRAY_SIZE);
        end
    end

    assign last_row  = ({1'b0, row_cnt_q} == (rows_q - CNT_W'(1)));
    assign start_acc = (state_q == ST_IDLE) && bus.start;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        rows_d    = rows_q;
        row_cnt_d = row_cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    base_d    = bus.base_addr;
                    rows_d    = eff_rows;
                    row_cnt_d = '0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Address addition truncates to ADDR_WIDTH, giving the silent wrap.
                wr_addr_d = base_q + ADDR_WIDTH'(row_cnt_q);
                wr_data_d = bus.quant_data;
                state_d   = ST_WRITE;
            end
            ST_WRITE: begin
                if (bus.wr_ready) begin
                    if (last_row) begin
                        state_d = ST_DONE;
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                        state_d   = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            base_q    <= '0;
            rows_q    <= '0;
            row_cnt_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            rows_q    <= rows_d;
            row_cnt_q <= row_cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Status and handshake outputs decode straight from the state register,
    // so an asynchronous reset clears them without waiting for a clock.
    assign bus.row_sel  = (state_q == ST_FETCH) ? row_cnt_q : '0;
    assign bus.wr_valid = (state_q == ST_WRITE);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

`ifdef WB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_acc) begin
            stall_cnt_d = '0;
        end else if (state_q == ST_WRITE && !bus.wr_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign bus.stall_cnt    = '0;
`endif
endmodule

// File: doc/quant_wb_ctrl.md
QUANT_WB_CTRL -- requirements
Module: quant_wb_ctrl

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 32, rows/columns of the systolic array.
REQ-002 SHALL have parameter OUTPUT_DATA_WIDTH, default 32, width of each quantized element.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, SRAM word address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request to drain one result tile; sampled only in IDLE.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH  SRAM address of the first row; latched on accepted start.
REQ-008 SHALL have port num_rows  input  $clog2(ARRAY_SIZE)+1  rows to drain; latched on accepted start.
REQ-009 SHALL have port row_sel  output  $clog2(ARRAY_SIZE)  array row presented to the quantizer.
REQ-010 SHALL have port quant_data  input  ARRAY_SIZE*OUTPUT_DATA_WIDTH  quantizer output for row_sel, valid in the same cycle.
REQ-011 SHALL have port wr_valid  output  1  SRAM write request.
REQ-012 SHALL have port wr_ready  input  1  SRAM accepts the write when high together with wr_valid.
REQ-013 SHALL have port wr_addr  output  ADDR_WIDTH  SRAM write address.
REQ-014 SHALL have port wr_data  output  ARRAY_SIZE*OUTPUT_DATA_WIDTH  registered row data.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the final row handshake.
REQ-017 SHALL have port stall_cnt  output  16  cycles with wr_valid=1 and wr_ready=0 (see Configuration).

Function
REQ-018 SHALL implement the states IDLE, FETCH, WRITE and DONE.
REQ-019 SHALL, in IDLE with start=1, latch base_addr and the effective row count, clear the row counter, and enter FETCH.
REQ-020 SHALL use an effective row count equal to ARRAY_SIZE when num_rows=0 or num_rows>ARRAY_SIZE, and equal to num_rows otherwise.
REQ-021 SHALL, in FETCH, drive row_sel = row counter, register quant_data into wr_data and base+row into wr_addr, and enter WRITE.
REQ-022 SHALL, in WRITE, hold wr_valid=1; wr_addr and wr_data SHALL stay stable until wr_ready=1.
REQ-023 SHALL, on a WRITE handshake, increment the row counter and go to FETCH, or go to DONE if that row was the last.
REQ-024 SHALL assert done=1 for exactly the one cycle spent in DONE, then return to IDLE.
REQ-025 SHALL compute wr_addr as (base + row) modulo 2^ADDR_WIDTH, wrapping silently.
REQ-026 SHALL ignore start outside IDLE, including start asserted during the DONE cycle.
REQ-027 SHALL take 2*N+1 cycles from the start-accept edge to the done edge for N rows with wr_ready held high, plus one cycle per stall cycle.
REQ-028 SHALL drive row_sel = 0 in every state except FETCH.
REQ-029 SHALL keep wr_valid=0 in every state except WRITE.

Reset
REQ-030 SHALL, while rst_n=0, force state IDLE and zero row_sel, wr_valid, wr_addr, wr_data, busy, done, stall_cnt, and all latched configuration.
REQ-031 SHALL, on reset mid-operation, abandon the tile immediately; the pending write is dropped, no done pulse follows, and the next start begins a fresh tile.

Configuration
REQ-032 SHALL, with WB_STALL_CNT_EN defined, clear stall_cnt on each accepted start and increment it, saturating at 16'hFFFF, in each cycle where wr_valid=1 and wr_ready=0.
REQ-033 SHALL, without WB_STALL_CNT_EN, tie stall_cnt to 0 and instantiate no counter logic.

Verification
REQ-034 SHALL cover: num_rows=4, base_addr=0x010, wr_ready=1 -> writes to 0x010..0x013 in row order, each wr_data equal to quant_data at row_sel 0..3, done 9 cycles after the start edge.
REQ-035 SHALL cover: num_rows=0 -> 32 writes, row_sel 0..31, single done pulse.
REQ-036 SHALL cover: base_addr=0x3FE, num_rows=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-037 SHALL cover: wr_ready low for 3 cycles on row 1 -> wr_addr/wr_data held, done delayed by 3 cycles, stall_cnt=3 (with WB_STALL_CNT_EN) or 0 (without).
REQ-038 SHALL cover: start pulsed during WRITE and during DONE -> ignored, no second tile.
REQ-039 SHALL cover: rst_n low during row 2 WRITE -> all outputs 0 asynchronously, no done; a new start with num_rows=1 -> one write, done.
